// File: rtl/pipe_rotator_pkg.sv
// Opcode encoding shared by the rotator top and its per-stage shifter.
package rot_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_PASS = 3'b000;
    localparam op_t OP_ROL  = 3'b001;
    localparam op_t OP_ROR  = 3'b010;
    localparam op_t OP_SLL  = 3'b011;
    localparam op_t OP_SRL  = 3'b100;
    localparam op_t OP_SRA  = 3'b101;
    localparam op_t OP_REV  = 3'b110;
    localparam op_t OP_RSVD = 3'b111;

endpackage

// File: rtl/pipe_rotator_stage.sv
// One log-shifter stage: moves data by 2^K when amount bit K is set, then
// registers data, opcode, amount, sign and valid. Holds everything when en=0.
module rot_stage
    import rot_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int K     = 0,
    parameter int SW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d_in,
    input  op_t              op_in,
    input  logic [SW-1:0]    amt_in,
    input  logic             sgn_in,
    input  logic             vld_in,
    output logic [WIDTH-1:0] d_q,
    output op_t              op_q,
    output logic [SW-1:0]    amt_q,
    output logic             sgn_q,
    output logic             vld_q
);

    localparam int SH = 1 << K;

    logic [WIDTH-1:0] d_sh;

    // Shift/rotate by this stage's fixed distance; PASS, REV and reserved
    // were settled before stage 0 and just flow through here.
    always_comb begin
        d_sh = d_in;
        if (amt_in[K]) begin
            case (op_in)
                OP_ROL:  d_sh = {d_in[WIDTH-1-SH:0], d_in[WIDTH-1:WIDTH-SH]};
                OP_ROR:  d_sh = {d_in[SH-1:0], d_in[WIDTH-1:SH]};
                OP_SLL:  d_sh = {d_in[WIDTH-1-SH:0], {SH{1'b0}}};
                OP_SRL:  d_sh = {{SH{1'b0}}, d_in[WIDTH-1:SH]};
                OP_SRA:  d_sh = {{SH{sgn_in}}, d_in[WIDTH-1:SH]};
                default: d_sh = d_in;
            endcase
        end
    end

    // Stage register; advances only when the whole pipe advances.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_q   <= '0;
            op_q  <= OP_PASS;
            amt_q <= '0;
            sgn_q <= 1'b0;
            vld_q <= 1'b0;
        end else if (en) begin
            d_q   <= d_sh;
            op_q  <= op_in;
            amt_q <= amt_in;
            sgn_q <= sgn_in;
            vld_q <= vld_in;
        end
    end

endmodule

// File: rtl/pipe_rotator.sv
// Pipelined barrel rotator/shifter: SW log-shifter stages with a
// valid/ready handshake. The last stage register is the output register.
module pipe_rotator
    import rot_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i,
    input  logic [SW-1:0]    s,
    input  logic [2:0]       c,
    input  logic             i_valid,
    output logic             i_ready,
    output logic [WIDTH-1:0] o,
    output logic             o_valid,
    input  logic             o_ready,
    output logic             o_err
);

    logic [SW:0][WIDTH-1:0] data_pipe;
    logic [SW:0][2:0]       op_pipe;
    logic [SW:0][SW-1:0]    amt_pipe;
    logic [SW:0]            sgn_pipe;
    logic [SW:0]            vld_pipe;
    logic [WIDTH-1:0]       d0;
    logic                   adv;

    // Whole pipe moves unless a result is stuck at the output.
    assign adv     = !(o_valid && !o_ready);
    assign i_ready = adv;

    // Stage-0 decode: bit reverse and the reserved zero are resolved here so
    // the shifter stages only ever see shift/rotate work.
    always_comb begin
        d0 = i;
        case (c)
            OP_REV:  for (int b = 0; b < WIDTH; b++) d0[b] = i[WIDTH-1-b];
            OP_RSVD: d0 = '0;
            default: d0 = i;
        endcase
    end

    assign data_pipe[0] = d0;
    assign op_pipe[0]   = c;
    assign amt_pipe[0]  = s;
    assign sgn_pipe[0]  = i[WIDTH-1];
    assign vld_pipe[0]  = i_valid;

    for (genvar k = 0; k < SW; k++) begin : g_stage
        rot_stage #(
            .WIDTH (WIDTH),
            .K     (k),
            .SW    (SW)
        ) u_stage (
            .clk    (clk),
            .rst    (rst),
            .en     (adv),
            .d_in   (data_pipe[k]),
            .op_in  (op_pipe[k]),
            .amt_in (amt_pipe[k]),
            .sgn_in (sgn_pipe[k]),
            .vld_in (vld_pipe[k]),
            .d_q    (data_pipe[k+1]),
            .op_q   (op_pipe[k+1]),
            .amt_q  (amt_pipe[k+1]),
            .sgn_q  (sgn_pipe[k+1]),
            .vld_q  (vld_pipe[k+1])
        );
    end

    assign o       = data_pipe[SW];
    assign o_valid = vld_pipe[SW];
    assign o_err   = (op_pipe[SW] == OP_RSVD);

    // Amount and sign are spent by the time they leave the last stage.
    logic unused_tail;
    assign unused_tail = ^{amt_pipe[SW], sgn_pipe[SW]};

endmodule

// File: tb/tb_pipe_rotator.sv
// Self-checking bench for pipe_rotator at WIDTH=8: directed vector table,
// hand-written multi-cycle sequences and a random sweep against a model.
module tb_pipe_rotator;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] i = '0;
    logic [2:0] s = '0;
    logic [2:0] c = '0;
    logic       i_valid = 1'b0;
    logic       i_ready;
    logic [7:0] o;
    logic       o_valid;
    logic       o_ready = 1'b1;
    logic       o_err;

    pipe_rotator #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .i(i), .s(s), .c(c),
        .i_valid(i_valid), .i_ready(i_ready),
        .o(o), .o_valid(o_valid), .o_ready(o_ready), .o_err(o_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] o;
        logic       err;
    } res_t;

    typedef struct {
        logic [7:0] i;
        logic [2:0] s;
        logic [2:0] c;
        logic [7:0] o;
        logic       err;
        string      name;
    } vec_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_out = 0;
    res_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference computed with plain integer arithmetic on the whole word.
    function automatic res_t model(input logic [7:0] a, input logic [2:0] sh, input logic [2:0] op);
        res_t r;
        int   ai, sa, n;
        ai = int'(a);
        n  = int'(sh);
        sa = a[7] ? ai - 256 : ai;
        r.err = 1'b0;
        case (op)
            3'd0: r.o = a;
            3'd1: r.o = 8'(((ai << n) | (ai >> (8 - n))) & 255);
            3'd2: r.o = 8'(((ai >> n) | (ai << (8 - n))) & 255);
            3'd3: r.o = 8'((ai << n) & 255);
            3'd4: r.o = 8'(ai >> n);
            3'd5: r.o = 8'((sa >>> n) & 255);
            3'd6: for (int b = 0; b < 8; b++) r.o[b] = a[7-b];
            default: begin r.o = 8'h00; r.err = 1'b1; end
        endcase
        return r;
    endfunction

    // One cycle of streaming traffic with scoreboard tracking.
    task automatic step(input logic iv, input logic [7:0] ii, input logic [2:0] is,
                        input logic [2:0] ic, input logic ordy, output logic acc);
        res_t e;
        @(negedge clk);
        i_valid = iv; i = ii; s = is; c = ic; o_ready = ordy;
        #1;
        acc = iv && i_ready;
        if (o_valid && o_ready) begin
            n_out++;
            if (sb.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL sb_extra: got output %0h want none", o);
            end else begin
                e = sb.pop_front();
                chk("sb_o", o, e.o);
                chk("sb_err", o_err, e.err);
            end
        end
        if (acc) sb.push_back(model(ii, is, ic));
    endtask

    // Single isolated beat with exact latency check.
    task automatic apply_vec(input vec_t v);
        @(negedge clk);
        i_valid = 1'b1; i = v.i; s = v.s; c = v.c; o_ready = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        @(negedge clk);
        chk({v.name, "_early"}, o_valid, 1'b0);
        @(negedge clk);
        chk({v.name, "_vld"}, o_valid, 1'b1);
        chk({v.name, "_o"}, o, v.o);
        chk({v.name, "_err"}, o_err, v.err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t       tbl[10];
        logic       acc, seen, ordy;
        logic [7:0] held;
        logic [7:0] bi[5];
        logic [7:0] got_o[4];
        int         got_k[4];
        int         ng, idx, stall, out0, accn, tries, stale;
        vec_t       v;

        tbl[0] = '{8'h96, 3'd3, 3'b001, 8'hB4, 1'b0, "rol3"};
        tbl[1] = '{8'h96, 3'd3, 3'b010, 8'hD2, 1'b0, "ror3"};
        tbl[2] = '{8'h96, 3'd3, 3'b011, 8'hB0, 1'b0, "sll3"};
        tbl[3] = '{8'h96, 3'd2, 3'b100, 8'h25, 1'b0, "srl2"};
        tbl[4] = '{8'h96, 3'd2, 3'b101, 8'hE5, 1'b0, "sra2"};
        tbl[5] = '{8'h96, 3'd4, 3'b000, 8'h96, 1'b0, "pass"};
        tbl[6] = '{8'h96, 3'd5, 3'b110, 8'h69, 1'b0, "rev"};
        tbl[7] = '{8'h96, 3'd3, 3'b111, 8'h00, 1'b1, "rsvd"};
        tbl[8] = '{8'h96, 3'd0, 3'b001, 8'h96, 1'b0, "rol0"};
        tbl[9] = '{8'h01, 3'd7, 3'b011, 8'h80, 1'b0, "sll7"};

        // Reset state
        #12;
        chk("rst_vld", o_valid, 1'b0);
        chk("rst_o", o, 8'h00);
        chk("rst_err", o_err, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_irdy", i_ready, 1'b1);

        foreach (tbl[k]) apply_vec(tbl[k]);

        // Back-to-back four shifts: results on consecutive cycles, in order
        ng = 0;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            o_ready = 1'b1;
            i_valid = (k < 4);
            if (k < 4) begin
                v = tbl[k + 1];
                i = v.i; s = v.s; c = v.c;
            end
            #1;
            if (o_valid && ng < 4) begin
                got_o[ng] = o; got_k[ng] = k; ng++;
            end
        end
        chk("b2b_count", ng, 4);
        for (int k = 0; k < 4; k++) begin
            chk("b2b_o", got_o[k], tbl[k + 1].o);
            chk("b2b_cyc", got_k[k], 3 + k);
        end

        // Back-pressure: 5 beats, 4-cycle stall after first output
        for (int k = 0; k < 5; k++) bi[k] = 8'($urandom);
        seen = 1'b0; stall = 0; idx = 0; out0 = n_out; held = '0;
        for (int cyc = 0; cyc < 60 && !(idx == 5 && sb.size() == 0); cyc++) begin
            ordy = !(seen && stall < 4);
            step(idx < 5, bi[idx % 5], 3'(idx + 1), 3'(1 + idx % 5), ordy, acc);
            if (!ordy) begin
                chk("bp_irdy", i_ready, 1'b0);
                chk("bp_vld", o_valid, 1'b1);
                if (stall == 0) held = o;
                else chk("bp_hold", o, held);
                stall++;
            end
            if (o_valid) seen = 1'b1;
            if (acc) idx++;
        end
        chk("bp_count", n_out - out0, 5);
        chk("bp_sb_empty", sb.size(), 0);

        // Reset mid-stream with 3 beats in flight
        for (int k = 0; k < 3; k++) step(1'b1, 8'hFF, 3'd0, 3'b000, 1'b1, acc);
        @(posedge clk);
        #2;
        chk("mid_pre_vld", o_valid, 1'b1);
        rst = 1'b1;
        i_valid = 1'b0;
        #1;
        chk("mid_rst_vld", o_valid, 1'b0);
        chk("mid_rst_o", o, 8'h00);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        stale = 0;
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 8'h00, 3'd0, 3'b000, 1'b1, acc);
            if (o_valid) stale++;
        end
        chk("mid_stale", stale, 0);
        apply_vec(tbl[0]);

        // Random sweep: every opcode x every amount, random back-pressure
        out0 = n_out; accn = 0;
        for (int op = 0; op < 8; op++) begin
            for (int sh = 0; sh < 8; sh++) begin
                if ($urandom_range(0, 3) == 0)
                    step(1'b0, 8'h00, 3'd0, 3'd0, 1'($urandom_range(0, 1)), acc);
                tries = 0;
                do begin
                    step(1'b1, 8'($urandom), 3'(sh), 3'(op), ($urandom_range(0, 3) != 0), acc);
                    tries++;
                end while (!acc && tries < 50);
                if (acc) accn++;
                else begin
                    n_cmp++; n_bad++;
                    $display("FAIL sweep_accept: got stuck want accept");
                end
            end
        end
        for (int k = 0; k < 30 && sb.size() != 0; k++)
            step(1'b0, 8'h00, 3'd0, 3'd0, 1'b1, acc);
        chk("sweep_sb_empty", sb.size(), 0);
        chk("sweep_count", n_out - out0, accn);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
